// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Rate decoder for the LIF neuron's spike output. Counts spikes
//               over a fixed window of 2**WINDOW_LOG2 clock cycles and emits
//               the saturated count as an 8-bit rate word. The rate word sits
//               in a one-entry valid/ready buffer so the consumer can stall.
//
//               Optional build macro SPIKE_EDGE_EN:
//                 defined   - only rising edges of spike are counted (a
//                             level held high for k cycles counts once)
//                 undefined - every en=1 cycle with spike=1 is counted
//
// Ports       :
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   en          in   decode enable; low aborts the current window
//   spike       in   spike level from the neuron, sampled every clk
//   rate        out  [7:0] spike count of the last completed window
//   rate_valid  out  rate holds an unconsumed value
//   rate_ready  in   consumer accepts rate when rate_valid && rate_ready
//   overrun     out  sticky: a completed window was dropped (buffer full)
//   window_pos  out  [WINDOW_LOG2-1:0] current position in the window
//
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
    parameter int unsigned WINDOW_LOG2 = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   spike,
    output logic [7:0]             rate,
    output logic                   rate_valid,
    input  logic                   rate_ready,
    output logic                   overrun,
    output logic [WINDOW_LOG2-1:0] window_pos
);

    // Last position of a window: all ones.
    localparam logic [WINDOW_LOG2-1:0] c_last_pos = '1;

    logic [WINDOW_LOG2-1:0] r_pos;
    logic [7:0]             r_count;
    logic [7:0]             r_rate;
    logic                   r_rate_valid;
    logic                   r_overrun;

    logic                   w_counted;
    logic                   w_close;
    logic                   w_load_ok;
    logic [8:0]             w_sum;
    logic [7:0]             w_sat;

    // The decoder has two states, IDLE (en=0) and COUNT (en=1). Because the
    // state is exactly the current value of en, no separate state register
    // is kept: an IDLE cycle simply forces window_pos and the counter to 0
    // on the next edge, so the first COUNT cycle always sees window_pos=0.

`ifdef SPIKE_EDGE_EN
    logic r_spike_prev;

    // Previous-sample register runs in every state so an edge that rises
    // on the first counted cycle is detected correctly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spike_prev <= 1'b0;
        end else begin
            r_spike_prev <= spike;
        end
    end

    assign w_counted = en & spike & ~r_spike_prev;
`else
    assign w_counted = en & spike;
`endif

    // 9-bit add so a count of 255 plus one spike is caught and clamped.
    assign w_sum     = {1'b0, r_count} + {8'd0, w_counted};
    assign w_sat     = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_close   = en && (r_pos == c_last_pos);
    // The buffer can take the closing value if it is empty, or if its
    // current content is being consumed on this same edge.
    assign w_load_ok = !r_rate_valid || rate_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos        <= '0;
            r_count      <= 8'd0;
            r_rate       <= 8'd0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Window position and spike counter.
            if (!en) begin
                r_pos   <= '0;
                r_count <= 8'd0;
            end else begin
                r_pos   <= r_pos + 1'b1;
                r_count <= w_close ? 8'd0 : w_sat;
            end

            // Output buffer. A load takes priority over a plain consume;
            // a consume with no load simply empties the buffer and leaves
            // rate holding its last value.
            if (w_close) begin
                if (w_load_ok) begin
                    r_rate       <= w_sat;
                    r_rate_valid <= 1'b1;
                end else begin
                    r_overrun    <= 1'b1;
                end
            end else if (r_rate_valid && rate_ready) begin
                r_rate_valid <= 1'b0;
            end
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign overrun    = r_overrun;
    assign window_pos = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_rate_decoder
// Description : Directed self-checking bench for spike_rate_decoder. One
//               instance uses the default 32-cycle window, a second uses a
//               512-cycle window to exercise 8-bit saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_decoder;

`ifdef SPIKE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk;
    logic       rst_n, en, spike, rate_ready;
    logic [7:0] rate;
    logic       rate_valid, overrun;
    logic [4:0] window_pos;

    logic       rst9_n, en9, spike9, ready9;
    logic [7:0] rate9;
    logic       valid9, overrun9;
    logic [8:0] pos9;

    int checks = 0;
    int errors = 0;

    spike_rate_decoder #(.WINDOW_LOG2(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike      (spike),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .window_pos (window_pos)
    );

    spike_rate_decoder #(.WINDOW_LOG2(9)) dut9 (
        .clk        (clk),
        .rst_n      (rst9_n),
        .en         (en9),
        .spike      (spike9),
        .rate       (rate9),
        .rate_valid (valid9),
        .rate_ready (ready9),
        .overrun    (overrun9),
        .window_pos (pos9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        // ---------------- reset with en=1, spike=1 ----------------
        rst_n = 1'b0; en = 1'b1; spike = 1'b1; rate_ready = 1'b0;
        rst9_n = 1'b0; en9 = 1'b0; spike9 = 1'b0; ready9 = 1'b0;
        tick(); tick();
        check("rst_rate",     rate,       0);
        check("rst_valid",    rate_valid, 0);
        check("rst_overrun",  overrun,    0);
        check("rst_pos",      window_pos, 0);
        rst_n = 1'b1; rst9_n = 1'b1;
        #2;
        check("rel_valid",    rate_valid, 0);
        check("rel_pos",      window_pos, 0);
        en = 1'b0; spike = 1'b0;
        tick(); tick();
        check("idle_pos",     window_pos, 0);

        // ---------------- spike held high, ready=1 ----------------
        en = 1'b1; spike = 1'b1; rate_ready = 1'b1;
        repeat (31) tick();
        check("hold_pos31",   window_pos, 31);
        check("hold_novalid", rate_valid, 0);
        tick();
        check("hold_w1_valid", rate_valid, 1);
        check("hold_w1_rate",  rate, EDGE ? 1 : 32);
        check("hold_w1_pos",   window_pos, 0);
        tick();
        check("hold_consumed", rate_valid, 0);
        check("hold_rate_kept", rate, EDGE ? 1 : 32);
        repeat (30) tick();
        tick();
        check("hold_w2_valid", rate_valid, 1);
        check("hold_w2_rate",  rate, EDGE ? 0 : 32);

        // ---------------- alternating pattern / closing-cycle spike ----------------
        en = 1'b0; spike = 1'b0;
        tick();
        check("idle_consume", rate_valid, 0);
        en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            spike = (i % 2 == 0);
            tick();
        end
        check("alt_valid", rate_valid, 1);
        check("alt_rate",  rate, 16);
        for (int i = 0; i < 32; i++) begin
            spike = (i == 31);
            tick();
        end
        check("close_spike_rate", rate, 1);
        spike = 1'b0;
        repeat (32) tick();
        check("after_close_rate",  rate, 0);
        check("after_close_valid", rate_valid, 1);

        // ---------------- overrun: 5 then 7 spikes, ready=0 ----------------
        en = 1'b0; spike = 1'b0; rate_ready = 1'b1;
        tick();
        check("ovr_pre_valid", rate_valid, 0);
        rate_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            spike = (i < 10) && (i % 2 == 0);
            tick();
        end
        check("ovr_w1_valid",   rate_valid, 1);
        check("ovr_w1_rate",    rate, 5);
        check("ovr_w1_overrun", overrun, 0);
        for (int i = 0; i < 32; i++) begin
            spike = (i < 14) && (i % 2 == 0);
            tick();
        end
        check("ovr_w2_valid",   rate_valid, 1);
        check("ovr_w2_rate",    rate, 5);
        check("ovr_w2_overrun", overrun, 1);
        en = 1'b0; spike = 1'b0; rate_ready = 1'b1;
        tick();
        check("ovr_cons_valid",   rate_valid, 0);
        check("ovr_cons_rate",    rate, 5);
        check("ovr_cons_overrun", overrun, 1);
        rate_ready = 1'b0;

        // ---------------- abort mid-window, then 3 spikes ----------------
        en = 1'b1; spike = 1'b1;
        repeat (10) tick();
        check("abort_pos10", window_pos, 10);
        en = 1'b0; spike = 1'b0;
        tick();
        check("abort_pos0",  window_pos, 0);
        check("abort_valid", rate_valid, 0);
        en = 1'b1; rate_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            spike = (i == 5) || (i == 10) || (i == 15);
            tick();
        end
        check("reen_valid", rate_valid, 1);
        check("reen_rate",  rate, 3);
        en = 1'b0; spike = 1'b0;
        tick();

        // ---------------- 512-cycle window: saturation, same-edge consume+load ----------------
        en9 = 1'b1; spike9 = 1'b1; ready9 = 1'b0;
        repeat (512) tick();
        check("w9_valid",   valid9, 1);
        check("w9_rate",    rate9, EDGE ? 1 : 255);
        check("w9_pos",     pos9, 0);
        check("w9_overrun", overrun9, 0);
        for (int i = 0; i < 511; i++) begin
            spike9 = (i < 100);
            tick();
        end
        check("w9_pos511",   pos9, 511);
        check("w9_stable",   rate9, EDGE ? 1 : 255);
        ready9 = 1'b1; spike9 = 1'b0;
        tick();
        check("w9_load_valid",   valid9, 1);
        check("w9_load_rate",    rate9, EDGE ? 0 : 100);
        check("w9_load_overrun", overrun9, 0);
        en9 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Rate decoder for the LIF neuron's spike output. It is the inverse of the neuron's current-to-spike encoding: it counts spikes over a fixed window of 2^WINDOW_LOG2 clock cycles and emits the count as an 8-bit rate word. The output uses a one-entry valid/ready buffer so a downstream consumer (readout mux, next neuron stage's current input) can stall.

Parameters:
WINDOW_LOG2, 5, log2 of the window length in cycles (legal 1..9; default window is 32 cycles)

Ports:
clk  input  1  clock
rst_n  input  1  reset: synchronous, active-low
en  input  1  decode enable; low aborts the current window
spike  input  1  spike level from the neuron, sampled every clk
rate  output  8  spike count of the last completed window, saturated at 255
rate_valid  output  1  rate holds an unconsumed value
rate_ready  input  1  consumer accepts rate when rate_valid && rate_ready
overrun  output  1  sticky; a completed window was dropped because the buffer was full
window_pos  output  WINDOW_LOG2  current position in the window (0..2^WINDOW_LOG2-1)

Behaviour:
- Reset (rst_n low at posedge) forces rate=0, rate_valid=0, overrun=0, window_pos=0, spike counter=0, and the edge register (if present) to 0. Reset mid-window discards the partial count and any buffered value.
- States:
  - IDLE (en=0): window_pos and the spike counter are held at 0; the output buffer and overrun are unaffected, and a buffered value can still be consumed.
  - COUNT (en=1): window_pos increments by 1 each cycle and wraps from 2^WINDOW_LOG2-1 to 0.
  - Transitions: IDLE->COUNT on en=1 (the first counted cycle has window_pos=0). COUNT->IDLE on en=0; the partial window is discarded with no output.
- Counting: in COUNT, a "counted spike" is a cycle where spike=1 (see Optional Feature). The 8-bit counter increments on a counted spike and saturates at 255, never wrapping.
- Window close: occurs in the COUNT cycle with window_pos=2^WINDOW_LOG2-1.
  - The closing value is the counter plus that cycle's counted spike, saturated at 255.
  - On the same edge the counter returns to 0. The new window starts with 0 regardless of the closing cycle's spike.
- Buffer load at close:
  - The closing value loads into rate, with rate_valid=1 from the next cycle (latency 1 cycle after the close cycle), when the buffer is empty or is consumed in the close cycle (rate_valid && rate_ready). Simultaneous consume and load gives no overrun.
  - Otherwise the closing value is dropped, rate and rate_valid are unchanged, and overrun is set to 1. overrun clears only on reset.
- Handshake:
  - A consume with no load clears rate_valid on the next edge.
  - rate stays at its last value after consume.
  - rate is stable while rate_valid=1.
  - rate_ready is ignored while rate_valid=0.
- Widths: internal count arithmetic is 9-bit with saturation to 8 bits. window_pos is unsigned WINDOW_LOG2 bits.

Optional Feature:
Macro SPIKE_EDGE_EN.
- Defined: a counted spike is a rising edge, i.e. spike=1 and the previous-cycle sample=0. The previous-sample register updates every cycle, including in IDLE, and resets to 0. A spike held high for k cycles counts once. This matches the neuron's level-held spike output.
- Undefined: every cycle with spike=1 in COUNT is counted, and no previous-sample register exists.

Test Plan:
- Reset with spike=1 and en=1 -> while rst_n=0 and the cycle after release: rate=0, rate_valid=0, overrun=0, window_pos=0.
- WINDOW_LOG2=5, en=1, spike held 1, rate_ready=1 -> rate_valid pulses 1 cycle after window_pos=31 each window, with rate=32 (rate=1 with SPIKE_EDGE_EN; the first window only, then 0 for later windows since no new edge).
- spike pattern 1,0,1,0,... over 32 cycles -> rate=16 in both modes; a spike only in the closing cycle (window_pos=31) -> rate=1, and the next window starts at count 0.
- rate_ready=0 over two full windows of 5 then 7 spikes -> rate=5, rate_valid=1 held, overrun=1 after the second close. Then rate_ready=1 for one cycle -> rate_valid=0, rate stays 5, overrun stays 1.
- en=1 for 10 cycles with 10 spikes, then en=0 at window_pos=10 -> window_pos=0, no rate_valid. Re-enable for a full window with 3 spikes -> rate=3.
- WINDOW_LOG2=9, spike held 1 (level mode) -> rate=255 after 512 cycles, no wrap. rate_valid && rate_ready asserted in the close cycle -> new value loaded, overrun stays 0.
